// File: rtl/lfsr_descr_pkg.sv
// Shared types and LFSR helpers for the receive-side additive descrambler.
package lfsr_descr_pkg;

    localparam int unsigned       LFSR_W    = 16;
    // Taps 16/14/13/11 map to state bits 15/13/12/10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] DEF_SEED  = 16'h760C;
    localparam logic [LFSR_W-1:0] DEF_IDLE  = 16'h0001;

    typedef enum logic [1:0] {LOAD, RUN, BYPASS} descr_state_t;

    // State after n Fibonacci steps; n is at most LFSR_W for any legal word width.
    function automatic logic [LFSR_W-1:0] lfsr_adv(input logic [LFSR_W-1:0] state,
                                                   input int unsigned       n);
        logic [LFSR_W-1:0] s;
        s = state;
        for (int unsigned i = 0; i < LFSR_W; i++) begin
            if (i < n) begin
                s = {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr_descr_core.sv
// LFSR register for the descrambler: reseed, force-idle, or advance by one word.
module lfsr_descr_core
    import lfsr_descr_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter logic [LFSR_W-1:0] SEED     = DEF_SEED,
    parameter logic [LFSR_W-1:0] IDLE_VAL = DEF_IDLE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_seed,
    input  logic              load_idle,
    input  logic              advance,
    output logic [LFSR_W-1:0] lfsr_state
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_seed) begin
            lfsr_d = SEED;
        end else if (load_idle) begin
            lfsr_d = IDLE_VAL;
        end else if (advance) begin
            lfsr_d = lfsr_adv(lfsr_q, DATA_W);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_state = lfsr_q;

endmodule

// File: rtl/lfsr_descrambler.sv
// Additive LFSR descrambler with a single registered output stage.
// Define LFSR_DESCR_WORD_CNT_EN to build the completed-transfer counter on word_cnt.
module lfsr_descrambler
    import lfsr_descr_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter logic [LFSR_W-1:0] SEED     = DEF_SEED,
    parameter logic [LFSR_W-1:0] IDLE_VAL = DEF_IDLE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              descr_rst_n,
    input  logic              descr_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LFSR_W-1:0] lfsr_state,
    output logic [15:0]       word_cnt
);

    descr_state_t      state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              accept;
    logic              load_seed, load_idle, advance;
    logic [DATA_W-1:0] mask;

    assign mask      = lfsr_state[DATA_W-1:0];
    assign in_ready  = (state_q != LOAD) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign load_seed = !descr_rst_n || (state_q == LOAD);
    assign load_idle = (state_q == BYPASS);
    assign advance   = (state_q == RUN) && accept;

    lfsr_descr_core #(
        .DATA_W   (DATA_W),
        .SEED     (SEED),
        .IDLE_VAL (IDLE_VAL)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .load_seed  (load_seed),
        .load_idle  (load_idle),
        .advance    (advance),
        .lfsr_state (lfsr_state)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        if (!descr_rst_n) begin
            // Reseed drops any held word.
            state_d     = LOAD;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    state_d     = descr_en ? RUN : BYPASS;
                    out_valid_d = 1'b0;
                end
                RUN: begin
                    if (accept) begin
                        out_valid_d = 1'b1;
                        out_data_d  = in_data ^ mask;
                    end
                    if (!descr_en) begin
                        state_d = BYPASS;
                    end
                end
                BYPASS: begin
                    if (accept) begin
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                    end
                    // Re-enter through LOAD so RUN always starts from SEED.
                    if (descr_en) begin
                        state_d = LOAD;
                    end
                end
                default: begin
                    state_d     = LOAD;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef LFSR_DESCR_WORD_CNT_EN
    logic [15:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (!descr_rst_n) begin
            word_cnt_d = '0;
        end else if (out_valid_q && out_ready) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
`else
    assign word_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_descrambler.sv
// Directed-vector bench for lfsr_descrambler with a word-level reference model.
module tb_lfsr_descrambler;

    localparam logic [15:0] SEED  = 16'h760C;
    localparam logic [15:0] IDLE  = 16'h0001;
    localparam int          SEQ_N = 2048;

    logic        clock       = 1'b0;
    logic        reset       = 1'b0;
    logic        descr_rst_n = 1'b1;
    logic        descr_en    = 1'b1;
    logic [7:0]  in_data     = 8'h00;
    logic        in_valid    = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready   = 1'b1;
    logic [15:0] lfsr_state;
    logic [15:0] word_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // seq[k] is the LFSR value k single steps after SEED.
    logic [15:0] seq [SEQ_N];

    // Model: mode flags, words masked since reseed, output stage, transfer count.
    bit          m_load  = 1'b1;
    bit          m_run   = 1'b0;
    bit          m_idle  = 1'b0;
    int          m_words = 0;
    logic [7:0]  m_q[$];
    logic [15:0] m_cnt   = 16'h0000;

    logic [7:0]  gotq[$];
    bit          collect = 1'b0;

    lfsr_descrambler #(
        .DATA_W   (8),
        .SEED     (SEED),
        .IDLE_VAL (IDLE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .descr_rst_n (descr_rst_n),
        .descr_en    (descr_en),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .lfsr_state  (lfsr_state),
        .word_cnt    (word_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] step1(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_step();
        bit rdy, acc;
        logic [15:0] cur;
        if (!reset) begin
            m_load = 1'b1; m_run = 1'b0; m_idle = 1'b0; m_words = 0;
            m_q.delete(); m_cnt = 16'h0000;
            return;
        end
        rdy = !m_load && (m_q.size() == 0 || out_ready);
        acc = in_valid && rdy;
        if (m_q.size() != 0 && out_ready) begin
            void'(m_q.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        if (!descr_rst_n) begin
            m_load = 1'b1; m_idle = 1'b0; m_words = 0; m_q.delete(); m_cnt = 16'h0000;
        end else if (m_load) begin
            m_load = 1'b0; m_run = descr_en; m_idle = 1'b0; m_words = 0; m_q.delete();
        end else if (m_run) begin
            if (acc) begin
                cur = seq[8 * m_words];
                m_q.push_back(in_data ^ cur[7:0]);
                m_words++;
            end
            m_run = descr_en;
        end else begin
            if (acc) m_q.push_back(in_data);
            m_idle = 1'b1;
            if (descr_en) m_load = 1'b1;
        end
    endtask

    task automatic compare();
        logic exp_rdy;
        exp_rdy = !m_load && (m_q.size() == 0 || out_ready);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
        chk("lfsr_state", lfsr_state, m_idle ? IDLE : seq[8 * m_words]);
`ifdef LFSR_DESCR_WORD_CNT_EN
        chk("word_cnt", word_cnt, m_cnt);
`else
        chk("word_cnt", word_cnt, 16'h0000);
`endif
        if (collect && out_valid && out_ready) gotq.push_back(out_data);
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        compare();
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Holds in_valid until the word is taken; returns just after the accepting edge.
    task automatic send_word(input logic [7:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1'b1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for data %h, expected 1", d);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: no finish by %0t, expected earlier finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        logic [7:0]  bp_w [3];
        seq[0] = SEED;
        for (int k = 1; k < SEQ_N; k++) seq[k] = step1(seq[k-1]);

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_lfsr", lfsr_state, 16'h760C);
        chk("rst_word_cnt", word_cnt, 16'h0000);
        chk("rst_in_ready", in_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk("load_in_ready", in_ready, 1'b0);

        // First RUN word uses SEED[7:0]; LFSR then sits 8 steps on
        send_word(8'h0C);
        chk("first_out_data", out_data, 8'h00);
        chk("first_out_valid", out_valid, 1'b1);
        chk("first_lfsr", lfsr_state, 16'h0CDF);
        send_word(8'h12);
        chk("second_out_data", out_data, 8'hCD);

        // Bypass
        descr_en = 1'b0;
        cyc(3);
        chk("bypass_lfsr", lfsr_state, 16'h0001);
        send_word(8'hA5);
        chk("bypass_out_data", out_data, 8'hA5);
        cyc(3);
        chk("bypass_lfsr_hold", lfsr_state, 16'h0001);

        // Loopback of 0x00..0x3F through a reference scrambler
        descr_en    = 1'b1;
        descr_rst_n = 1'b0;
        cyc(1);
        descr_rst_n = 1'b1;
        cyc(1);
        gotq.delete();
        collect = 1'b1;
        for (int i = 0; i < 64; i++) begin
            m = seq[8 * i];
            send_word(8'(i) ^ m[7:0]);
        end
        cyc(2);
        collect = 1'b0;
        chk("loop_count", gotq.size(), 64);
        for (int i = 0; i < 64 && i < gotq.size(); i++) chk("loop_data", gotq[i], i);
`ifdef LFSR_DESCR_WORD_CNT_EN
        chk("loop_word_cnt", word_cnt, 16'd64);
`else
        chk("loop_word_cnt", word_cnt, 16'd0);
`endif

        // Backpressure: words 64..66 since reseed
        for (int k = 0; k < 3; k++) begin
            m = seq[8 * (64 + k)];
            bp_w[k] = (8'h11 * 8'(k + 1)) ^ m[7:0];
        end
        out_ready = 1'b0;
        #1;
        send_word(bp_w[0]);
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_hold_data", out_data, 8'h11);
        in_valid = 1'b1;
        in_data  = bp_w[1];
        cyc(3);
        chk("bp_hold_data2", out_data, 8'h11);
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_in_ready_held", in_ready, 1'b0);
        gotq.delete();
        collect   = 1'b1;
        out_ready = 1'b1;
        #1;
        send_word(bp_w[1]);
        send_word(bp_w[2]);
        cyc(2);
        collect = 1'b0;
        chk("bp_count", gotq.size(), 3);
        for (int k = 0; k < 3 && k < gotq.size(); k++) chk("bp_data", gotq[k], 8'h11 * (k + 1));
        chk("bp_lfsr", lfsr_state, seq[8 * 67]);

        // Reseed mid-stream with a word held and another offered
        out_ready = 1'b0;
        #1;
        send_word(8'h77);
        in_valid    = 1'b1;
        in_data     = 8'h5A;
        descr_rst_n = 1'b0;
        cyc(1);
        descr_rst_n = 1'b1;
        chk("reseed_out_valid", out_valid, 1'b0);
        chk("reseed_lfsr", lfsr_state, 16'h760C);
        chk("reseed_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        cyc(2);
        in_valid = 1'b0;
        chk("reseed_first_data", out_data, 8'h56);
        chk("reseed_first_valid", out_valid, 1'b1);
        cyc(2);

`ifdef LFSR_DESCR_WORD_CNT_EN
        // Counter wrap: 65537 transfers in bypass
        descr_en    = 1'b0;
        descr_rst_n = 1'b0;
        cyc(1);
        descr_rst_n = 1'b1;
        for (int i = 0; i < 65537; i++) send_word(8'h3C);
        cyc(2);
        chk("wrap_word_cnt", word_cnt, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
